// File: rtl/phv_writeback_stage.sv
// PHV write-back stage: merges the ALU result into one PHV field and buffers the
// updated PHV in a 2-entry FIFO with a valid/ready output handshake.
module phv_writeback_stage #(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned NUM_FIELDS  = 4,
    parameter int unsigned SEL_WIDTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [NUM_FIELDS*COUNT_WIDTH-1:0] i_phv,
    input  logic [COUNT_WIDTH-1:0]            i_result,
    input  logic                              i_wr_en,
    input  logic [SEL_WIDTH-1:0]              i_dst_field,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [NUM_FIELDS*COUNT_WIDTH-1:0] o_phv,
    output logic [31:0]                       o_pkt_count,
    output logic                              o_sel_err
);

    localparam int unsigned PhvWidth = NUM_FIELDS * COUNT_WIDTH;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e              state_q, state_d;
    logic [PhvWidth-1:0] head_q, head_d;
    logic [PhvWidth-1:0] tail_q, tail_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                sel_err_q, sel_err_d;

    logic [PhvWidth-1:0] merged;
    logic                sel_hit;
    logic                accept;
    logic                deliver;

    always_comb begin
        merged  = i_phv;
        sel_hit = 1'b0;
        for (int k = 0; k < int'(NUM_FIELDS); k++) begin
            if (i_dst_field == SEL_WIDTH'(k)) begin
                sel_hit = 1'b1;
                if (i_wr_en) begin
                    merged[k*COUNT_WIDTH +: COUNT_WIDTH] = i_result;
                end
            end
        end
    end

    // Handshake flags come from registered occupancy only.
    assign o_ready = (state_q != StFull);
    assign o_valid = (state_q != StEmpty);
    assign accept  = i_valid & o_ready;
    assign deliver = o_valid & i_ready;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = deliver ? cnt_q + 32'd1 : cnt_q;
        sel_err_d = sel_err_q | (accept & i_wr_en & ~sel_hit);
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    head_d  = merged;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && deliver) begin
                    head_d = merged;
                end else if (accept) begin
                    tail_d  = merged;
                    state_d = StFull;
                end else if (deliver) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (deliver) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign o_phv       = head_q;
    assign o_pkt_count = cnt_q;
    assign o_sel_err   = sel_err_q;

endmodule
